// File: rtl/sqrt_iterative_param.sv
// Multi-cycle unsigned integer square root, restoring digit recurrence.
// Retires BITS_PER_CYCLE root bits per clock; floor or round-to-nearest result plus floor remainder.

module sqrt_step #(
   parameter int H = 16
) (
   input  logic [H+1:0] rem,
   input  logic [H-1:0] root,
   input  logic [1:0]   pair,
   output logic [H+1:0] rem_n,
   output logic [H-1:0] root_n
);
   logic [H+1:0] rem_sh;
   logic [H+1:0] sub;
   logic         ge;

   // rem stays below 2*root+1, so the shifted value always fits in H+2 bits
   assign rem_sh = (rem << 2) | {{H{1'b0}}, pair};
   assign sub    = {root, 2'b01};
   assign ge     = (rem_sh >= sub);
   assign rem_n  = ge ? (rem_sh - sub) : rem_sh;
   assign root_n = (root << 1) | {{(H-1){1'b0}}, ge};
endmodule

module sqrt_iterative_param #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [WIDTH-1:0]   d,
   input  logic               round_mode,
   output logic [WIDTH/2-1:0] q,
   output logic [WIDTH/2:0]   r,
   output logic               sat,
   output logic               busy,
   output logic               ready
);
   localparam int H    = WIDTH / 2;
   localparam int BPC  = BITS_PER_CYCLE;
   localparam int ITER = WIDTH / (2 * BPC);
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] rad;
   logic [H+1:0]     rem_q;
   logic [H-1:0]     root_q;
   logic             mode;
   logic [CW-1:0]    cnt;

   logic [BPC:0][H+1:0] rem_c;
   logic [BPC:0][H-1:0] root_c;
   logic [H-1:0]        root_f;
   logic [H+1:0]        rem_f;
   logic                up;

   assign rem_c[0]  = rem_q;
   assign root_c[0] = root_q;

   // One recurrence step per retired bit, chained combinationally within the cycle
   for (genvar g = 0; g < BPC; g++) begin : g_step
      sqrt_step #(.H(H)) u_step (
         .rem    (rem_c[g]),
         .root   (root_c[g]),
         .pair   (rad[WIDTH-1-2*g -: 2]),
         .rem_n  (rem_c[g+1]),
         .root_n (root_c[g+1])
      );
   end

   assign root_f = root_c[BPC];
   assign rem_f  = rem_c[BPC];
   // d - root^2 > root means d lies past the midpoint root + 1/2
   assign up     = (rem_f > {2'b00, root_f});

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         rad    <= '0;
         rem_q  <= '0;
         root_q <= '0;
         mode   <= 1'b0;
         cnt    <= '0;
         q      <= '0;
         r      <= '0;
         sat    <= 1'b0;
         busy   <= 1'b0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rad    <= d;
                  mode   <= round_mode;
                  rem_q  <= '0;
                  root_q <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               rad    <= rad << (2 * BPC);
               rem_q  <= rem_f;
               root_q <= root_f;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  cnt   <= '0;
                  r     <= (H+1)'(rem_f);
                  if (mode && up && (&root_f)) begin
                     q   <= '1;
                     sat <= 1'b1;
                  end else if (mode && up) begin
                     q   <= root_f + 1'b1;
                     sat <= 1'b0;
                  end else begin
                     q   <= root_f;
                     sat <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sqrt_iterative_param.sv
// Directed bench for sqrt_iterative_param: three configurations sharing one clock.
// Expected values are hand-computed integer square roots.

module tb_sqrt_iterative_param;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   // dut0: WIDTH=32 BPC=1, dut1: WIDTH=32 BPC=4, dut2: WIDTH=16 BPC=2
   logic        s0 = 0, m0 = 0, sat0, busy0, rdy0;
   logic [31:0] d0 = '0;
   logic [15:0] q0;
   logic [16:0] r0;
   logic        s1 = 0, m1 = 0, sat1, busy1, rdy1;
   logic [31:0] d1 = '0;
   logic [15:0] q1;
   logic [16:0] r1;
   logic        s2 = 0, m2 = 0, sat2, busy2, rdy2;
   logic [15:0] d2 = '0;
   logic [7:0]  q2;
   logic [8:0]  r2;

   int total = 0;
   int bad   = 0;

   sqrt_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut0 (
      .clk(clk), .clr(clr), .start(s0), .d(d0), .round_mode(m0),
      .q(q0), .r(r0), .sat(sat0), .busy(busy0), .ready(rdy0));
   sqrt_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut1 (
      .clk(clk), .clr(clr), .start(s1), .d(d1), .round_mode(m1),
      .q(q1), .r(r1), .sat(sat1), .busy(busy1), .ready(rdy1));
   sqrt_iterative_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .clr(clr), .start(s2), .d(d2), .round_mode(m2),
      .q(q2), .r(r2), .sat(sat2), .busy(busy2), .ready(rdy2));

   function automatic logic rdy_of(input int w);
      case (w)
         0:       return rdy0;
         1:       return rdy1;
         default: return rdy2;
      endcase
   endfunction

   // One-cycle start pulse; returns at the falling edge just after the accepting edge
   task automatic go(input int w, input logic [31:0] dv, input logic m);
      @(negedge clk);
      case (w)
         0: begin s0 = 1; d0 = dv; m0 = m; end
         1: begin s1 = 1; d1 = dv; m1 = m; end
         default: begin s2 = 1; d2 = dv[15:0]; m2 = m; end
      endcase
      @(negedge clk);
      s0 = 0; s1 = 0; s2 = 0;
   endtask

   // Cycles until ready is seen; an expired bound counts as a failure
   task automatic wait_rdy(input int w, input int limit, output int lat);
      lat = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (rdy_of(w)) begin
            lat = i;
            return;
         end
      end
      total++; bad++;
      $display("FAIL timeout dut%0d: no ready within %0d cycles", w, limit);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if ({busy0, rdy0, sat0, q0, r0} !== '0) begin
         bad++; $display("FAIL reset dut0: busy=%b ready=%b sat=%b q=%h r=%h, need all 0", busy0, rdy0, sat0, q0, r0);
      end
      total++;
      if ({busy1, rdy1, sat1, q1, r1, busy2, rdy2, sat2, q2, r2} !== '0) begin
         bad++; $display("FAIL reset dut1/2: q1=%h r1=%h q2=%h r2=%h busy=%b%b, need all 0", q1, r1, q2, r2, busy1, busy2);
      end
      clr = 0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat;
      go(0, 32'h4000_0000, 1'b0);
      d0 = 32'hDEAD_BEEF; m0 = 1'b1;  // must not disturb the running operation
      total++;
      if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy: busy=%b need 1", busy0); end
      wait_rdy(0, 40, lat);
      total++;
      if (lat != 16) begin bad++; $display("FAIL basic_latency: got %0d need 16", lat); end
      total++;
      if ({q0, r0, sat0, busy0} !== {16'h8000, 17'h0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL basic_result: q=%h r=%h sat=%b busy=%b need q=8000 r=0 sat=0 busy=0", q0, r0, sat0, busy0);
      end
      @(negedge clk);
      total++;
      if ({rdy0, busy0, q0} !== {1'b0, 1'b0, 16'h8000}) begin
         bad++; $display("FAIL basic_pulse: ready=%b busy=%b q=%h need 0 0 8000", rdy0, busy0, q0);
      end
   endtask

   task automatic test_max;
      int lat;
      go(0, 32'hFFFF_FFFF, 1'b0);
      wait_rdy(0, 40, lat);
      total++;
      if ({q0, r0, sat0} !== {16'hFFFF, 17'h1FFFE, 1'b0}) begin
         bad++; $display("FAIL max_floor: q=%h r=%h sat=%b need ffff 1fffe 0", q0, r0, sat0);
      end
      go(0, 32'hFFFF_FFFF, 1'b1);
      wait_rdy(0, 40, lat);
      total++;
      if ({q0, r0, sat0} !== {16'hFFFF, 17'h1FFFE, 1'b1}) begin
         bad++; $display("FAIL max_round: q=%h r=%h sat=%b need ffff 1fffe 1", q0, r0, sat0);
      end
   endtask

   typedef struct packed {
      logic [31:0] d;
      logic        m;
      logic [15:0] q;
      logic [16:0] r;
      logic        s;
   } vec_t;

   task automatic test_small;
      vec_t tv [8];
      int lat;
      tv[0] = '{32'd8,          1'b0, 16'd2,      17'd4,  1'b0};
      tv[1] = '{32'd8,          1'b1, 16'd3,      17'd4,  1'b0};
      tv[2] = '{32'd2,          1'b1, 16'd1,      17'd1,  1'b0};
      tv[3] = '{32'd3,          1'b1, 16'd2,      17'd2,  1'b0};
      tv[4] = '{32'd0,          1'b0, 16'd0,      17'd0,  1'b0};
      tv[5] = '{32'd0,          1'b1, 16'd0,      17'd0,  1'b0};
      tv[6] = '{32'd99,         1'b1, 16'd10,     17'd18, 1'b0};
      tv[7] = '{32'hFFFE_0001,  1'b1, 16'hFFFF,   17'd0,  1'b0};
      for (int i = 0; i < 8; i++) begin
         go(0, tv[i].d, tv[i].m);
         wait_rdy(0, 40, lat);
         total++;
         if ({q0, r0, sat0} !== {tv[i].q, tv[i].r, tv[i].s}) begin
            bad++; $display("FAIL small[%0d] d=%0h mode=%b: q=%0h r=%0h sat=%b need q=%0h r=%0h sat=%b",
                            i, tv[i].d, tv[i].m, q0, r0, sat0, tv[i].q, tv[i].r, tv[i].s);
         end
      end
   endtask

   task automatic test_bpc4;
      int lat;
      go(1, 32'h4000_0000, 1'b0);
      wait_rdy(1, 20, lat);
      total++;
      if (lat != 4) begin bad++; $display("FAIL bpc4_latency: got %0d need 4", lat); end
      total++;
      if ({q1, r1, sat1} !== {16'h8000, 17'h0, 1'b0}) begin
         bad++; $display("FAIL bpc4_result: q=%h r=%h sat=%b need 8000 0 0", q1, r1, sat1);
      end
      go(1, 32'hFFFF_FFFF, 1'b1);
      wait_rdy(1, 20, lat);
      total++;
      if ({q1, r1, sat1} !== {16'hFFFF, 17'h1FFFE, 1'b1}) begin
         bad++; $display("FAIL bpc4_round: q=%h r=%h sat=%b need ffff 1fffe 1", q1, r1, sat1);
      end
   endtask

   task automatic test_w16;
      int lat;
      go(2, 32'h0000_FFFF, 1'b0);
      wait_rdy(2, 20, lat);
      total++;
      if (lat != 4) begin bad++; $display("FAIL w16_latency: got %0d need 4", lat); end
      total++;
      if ({q2, r2, sat2} !== {8'hFF, 9'h1FE, 1'b0}) begin
         bad++; $display("FAIL w16_result: q=%h r=%h sat=%b need ff 1fe 0", q2, r2, sat2);
      end
      go(2, 32'h0000_FFFF, 1'b1);
      wait_rdy(2, 20, lat);
      total++;
      if ({q2, r2, sat2} !== {8'hFF, 9'h1FE, 1'b1}) begin
         bad++; $display("FAIL w16_round: q=%h r=%h sat=%b need ff 1fe 1", q2, r2, sat2);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      go(0, 32'h4000_0000, 1'b0);
      repeat (4) @(negedge clk);
      s0 = 1; d0 = 32'h100; m0 = 1'b1;  // ignored: unit is busy
      @(negedge clk);
      s0 = 0;
      wait_rdy(0, 40, lat);
      total++;
      if (lat != 11) begin bad++; $display("FAIL ignore_latency: got %0d need 11", lat); end
      total++;
      if ({q0, r0, sat0} !== {16'h8000, 17'h0, 1'b0}) begin
         bad++; $display("FAIL ignore_result: q=%h r=%h sat=%b need 8000 0 0", q0, r0, sat0);
      end
      // start in the ready cycle
      s0 = 1; d0 = 32'h100; m0 = 1'b0;
      @(negedge clk);
      s0 = 0;
      total++;
      if ({busy0, q0} !== {1'b1, 16'h8000}) begin
         bad++; $display("FAIL b2b_hold: busy=%b q=%h need 1 8000", busy0, q0);
      end
      wait_rdy(0, 40, lat);
      total++;
      if ({lat, q0, r0} !== {32'd16, 16'h10, 17'h0}) begin
         bad++; $display("FAIL b2b_result: lat=%0d q=%h r=%h need 16 10 0", lat, q0, r0);
      end
   endtask

   task automatic test_held;
      int lat_a, lat_b;
      @(negedge clk);
      s0 = 1; d0 = 32'h100; m0 = 1'b0;
      wait_rdy(0, 40, lat_a);
      wait_rdy(0, 40, lat_b);
      s0 = 0;
      total++;
      if (lat_a != 17 || lat_b != 17) begin
         bad++; $display("FAIL held_spacing: got %0d,%0d need 17,17", lat_a, lat_b);
      end
      @(negedge clk);
      total++;
      if ({busy0, q0} !== {1'b0, 16'h10}) begin
         bad++; $display("FAIL held_stop: busy=%b q=%h need 0 10", busy0, q0);
      end
   endtask

   task automatic test_clr;
      int lat;
      logic seen;
      go(0, 32'h4000_0000, 1'b0);
      repeat (8) @(negedge clk);
      #2 clr = 1;
      #1;
      total++;
      if ({busy0, rdy0, sat0, q0, r0} !== '0) begin
         bad++; $display("FAIL clr_async: busy=%b ready=%b sat=%b q=%h r=%h need all 0", busy0, rdy0, sat0, q0, r0);
      end
      @(negedge clk);
      clr = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rdy0 || busy0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL clr_abandon: ready/busy seen=%b need 0", seen); end
      go(0, 32'd81, 1'b0);
      wait_rdy(0, 40, lat);
      total++;
      if ({lat, q0, r0} !== {32'd16, 16'd9, 17'd0}) begin
         bad++; $display("FAIL clr_recover: lat=%0d q=%0d r=%0d need 16 9 0", lat, q0, r0);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_max;
      test_small;
      test_bpc4;
      test_w16;
      test_back_to_back;
      test_held;
      test_clr;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/sqrt_iterative_param.md
# sqrt_iterative_param

Parametrised, multi-cycle unsigned integer square-root unit with start/busy/ready handshake, the next generation of the team's fixed 32-bit square-root core. It computes floor or round-to-nearest sqrt of a WIDTH-bit operand, returns the floor remainder, and retires BITS_PER_CYCLE result bits per clock so latency can be traded against logic depth. It sits beside the divider/reciprocal units in the arithmetic datapath and is driven by a sequencer that issues one operation at a time.

## Interface
- WIDTH, 32, operand width; even, ≥ 4.
- BITS_PER_CYCLE, 1, result bits resolved per clock; must divide WIDTH/2 (1, 2, 4 typical).
- ITER (localparam), WIDTH/(2·BITS_PER_CYCLE), iteration cycles per operation.
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- d  in  WIDTH  unsigned radicand; captured when start is accepted.
- round_mode  in  1  0 = floor, 1 = round to nearest; captured with d.
- q  out  WIDTH/2  root result.
- r  out  WIDTH/2+1  floor remainder, d − floor(sqrt(d))².
- sat  out  1  rounding saturated q at all-ones.
- busy  out  1  operation in progress.
- ready  out  1  one-cycle pulse: q, r, sat valid.

## Operation
- States: IDLE (busy=0), RUN (busy=1). Iteration counter 0..ITER-1, width ceil(log2(ITER+1)).
- IDLE, start=1 at edge: latch d into shift register, round_mode into mode register; clear partial root and partial remainder; counter=0; → RUN. start while busy=1 ignored, no effect on any state.
- RUN, each edge: perform BITS_PER_CYCLE restoring digit-recurrence steps, each step:
  - rem' = (rem << 2) | top two bits of radicand register; shift radicand left 2.
  - trial = rem' − ((root << 2) | 1).
  - trial ≥ 0: rem = trial, root = (root << 1) | 1; else rem = rem', root = root << 1.
  - rem held at WIDTH/2+2 bits internally (sign bit for trial).
- On the edge completing iteration ITER-1: → IDLE, busy=0, ready=1; r = final rem; q/sat per mode:
  - floor: q = root, sat = 0.
  - round: if rem > root (equivalently d > root² + root) q = root+1, else q = root; if root+1 would overflow WIDTH/2 bits, q = all-ones, sat = 1.
  - Exact half cannot occur for integers; no tie rule needed.
- q, r, sat hold their values until the next accepted operation completes; they are not cleared at start.
- d and round_mode changes during RUN have no effect.

## Timing
- Reset (clr=1, any time, asynchronous): state IDLE, busy=0, ready=0, q=0, r=0, sat=0, counter=0, internal registers 0. Reset mid-RUN abandons the operation; no ready pulse follows.
- Start accepted at edge E0 → busy=1 after E0. Result on edge E_ITER: busy=0 and ready=1 after E_ITER, ready back to 0 after E_ITER+1 unless a new completion occurs.
- Latency start-edge to ready: ITER cycles (16 for WIDTH=32, BITS_PER_CYCLE=1; 4 for BITS_PER_CYCLE=4).
- Back-to-back: start high in the cycle ready=1 (busy=0) is accepted on the next edge; throughput one operation per ITER+1 cycles.
- start held high continuously: new operation accepted each time busy falls.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=32, BPC=1, d=0x40000000, floor: start for one cycle -> busy for 16 cycles, ready pulse on 16th edge, q=0x8000, r=0, sat=0.
- d=0xFFFFFFFF: floor -> q=0xFFFF, r=0x1FFFE, sat=0; round -> q=0xFFFF, r=0x1FFFE, sat=1.
- Rounding, small values: d=8 floor -> q=2, r=4; round -> q=3; d=2 round -> q=1, r=1; d=3 round -> q=2, r=2; d=0 -> q=0, r=0.
- BPC=4, d=0x40000000 -> ready 4 cycles after start, q=0x8000; WIDTH=16, BPC=2, d=0xFFFF -> q=0xFF, r=0x1FE after 4 cycles.
- Start re-asserted with d=0x100 at cycle 5 of an operation on d=0x40000000 -> ignored, q=0x8000; start with d=0x100 in the ready cycle -> next result q=0x10, r=0.
- clr asserted at cycle 8 of an operation -> busy, ready, q, r, sat immediately 0; no ready pulse; subsequent start with d=81 -> q=9, r=0.
